// File: rtl/dm_cache_initiator_if.sv
// CPU request/response and RAM handshake bundle for the direct-mapped cache controller.
// master = the cache controller, slave = the CPU/RAM environment around it.
interface dm_cache_initiator_if;
    logic       cpu_req;
    logic       cpu_we;
    logic [9:0] cpu_addr;
    logic [9:0] cpu_wdata;
    logic [9:0] cpu_rdata;
    logic       cpu_ready;
    logic       cpu_busy;
    logic       mem_req;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic       mem_ready;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ready,
        output cpu_rdata, cpu_ready, cpu_busy, mem_req, mem_we, mem_addr
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ready,
        input  cpu_rdata, cpu_ready, cpu_busy, mem_req, mem_we, mem_addr
    );
endinterface

// File: rtl/dm_cache_initiator.sv
// Direct-mapped write-through cache: read hit completes 2 cycles after sampling, misses/writes go to RAM.
// Latency: hit -> cpu_ready at N+2; miss/write -> mem_req N+2, cpu_ready N+6 (3-cycle RAM).
// Backpressure: one request at a time; cpu_req ignored while busy; stalls on mem_ready=0 with no timeout.
module dm_cache_initiator #(
    parameter int LINES = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dm_cache_initiator_if.master bus,
    inout  wire  [19:0]          mem_data,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt
);
    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = 9 - INDEX_W;

    typedef enum logic [2:0] {IDLE, TAG, MREQ, MWAIT_LO, MWAIT_HI, RESP} state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [9:0]         addr_q, addr_d;
    logic [9:0]         wdata_q, wdata_d;
    logic [9:0]         cpu_rdata_q, cpu_rdata_d;
    logic               cpu_ready_q, cpu_ready_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [9:0]         mem_addr_q, mem_addr_d;
    logic               drive_q, drive_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic [LINES-1:0]   valid_q, valid_d;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [19:0]        line_mem [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [19:0]        cur_line;
    logic               hit;
    logic               arr_we;
    logic [19:0]        arr_line;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign idx      = addr_q[INDEX_W:1];
    assign tag      = addr_q[9:INDEX_W+1];
    assign cur_line = line_mem[idx];
    assign hit      = valid_q[idx] && (tag_mem[idx] == tag);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        drive_d     = 1'b0;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        valid_d     = valid_q;
        arr_we      = 1'b0;
        arr_line    = cur_line;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    we_d    = bus.cpu_we;
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    state_d = TAG;
                end
            end
            TAG: begin
                if (hit) hit_cnt_d  = sat_inc(hit_cnt_q);
                else     miss_cnt_d = sat_inc(miss_cnt_q);
                if (hit && !we_q) begin
                    cpu_rdata_d = addr_q[0] ? cur_line[19:10] : cur_line[9:0];
                    state_d     = RESP;
                end else begin
                    mem_addr_d = addr_q;
                    state_d    = MREQ;
                    // Write hit patches only the addressed half; write miss never allocates.
                    if (we_q && hit) begin
                        arr_we   = 1'b1;
                        arr_line = addr_q[0] ? {wdata_q, cur_line[9:0]} : {cur_line[19:10], wdata_q};
                    end
                end
            end
            MREQ: begin
                if (bus.mem_ready) begin
                    mem_req_d = 1'b1;
                    mem_we_d  = we_q;
                    drive_d   = we_q;
                    state_d   = MWAIT_LO;
                end
            end
            MWAIT_LO: begin
                if (!bus.mem_ready) state_d = MWAIT_HI;
            end
            MWAIT_HI: begin
                if (bus.mem_ready) begin
                    if (!we_q) begin
                        arr_we       = 1'b1;
                        arr_line     = mem_data;
                        valid_d[idx] = 1'b1;
                        cpu_rdata_d  = addr_q[0] ? mem_data[19:10] : mem_data[9:0];
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                cpu_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            drive_q     <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            drive_q     <= drive_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            valid_q     <= valid_d;
        end
    end

    // Tag/data storage carries no reset; valid_q alone decides residency.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_mem[idx]  <= tag;
            line_mem[idx] <= arr_line;
        end
    end

    assign mem_data      = drive_q ? {wdata_q, wdata_q} : 20'bz;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.cpu_busy  = (state_q != IDLE);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;
endmodule

// File: tb/tb_dm_cache_initiator.sv
// Directed bench for dm_cache_initiator: handshaked RAM model, reference memory and residency model.
module tb_dm_cache_initiator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    wire  [19:0] mem_data;
    logic [1:0]  hit_cnt, miss_cnt;

    dm_cache_initiator_if bus();

    dm_cache_initiator #(.LINES(8), .CNT_W(2)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.master),
        .mem_data (mem_data),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // RAM: accepts a pulse while ready, goes busy for ram_lat cycles, drives the bus unless being written.
    logic [9:0] ram [1024];
    bit         init_done = 1'b0;
    logic       ram_ready = 1'b1;
    int         busy_left = 0;
    int         ram_lat   = 1;

    function automatic logic [9:0] init_val(input logic [9:0] a);
        if (a == 10'd10) return 10'd5;
        if (a == 10'd11) return 10'd10;
        return a ^ 10'h155;
    endfunction

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_val(10'(i));
            init_done <= 1'b1;
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
            if (busy_left == 0) ram_ready <= 1'b1;
        end else if (bus.mem_req && ram_ready) begin
            if (bus.mem_we)
                ram[bus.mem_addr] <= bus.mem_addr[0] ? mem_data[19:10] : mem_data[9:0];
            ram_ready <= 1'b0;
            busy_left = ram_lat;
        end
    end

    assign bus.mem_ready = ram_ready;
    assign mem_data = (!ram_ready || !bus.mem_we) ?
                      {ram[{bus.mem_addr[9:1], 1'b1}], ram[{bus.mem_addr[9:1], 1'b0}]} : 20'bz;

    // Reference model: memory contents, which lines are resident, and event counts.
    logic [9:0] mref [1024];
    bit         mvalid [8];
    int         mtag [8];
    int         mh, mm;
    int         last_req_k, last_rdy_k;
    logic [19:0] last_wr_bus;

    function automatic int sat(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic op(input logic we, input logic [9:0] a, input logic [9:0] wd);
        bit         hit, need_mem, seen_req, done;
        int         r;
        logic [9:0] exp_rd;
        logic [19:0] exp_line;
        hit      = mvalid[a[3:1]] && (mtag[a[3:1]] == int'(a[9:4]));
        need_mem = we || !hit;
        exp_rd   = mref[a];
        if (hit) mh++; else mm++;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd;
        @(negedge clk);
        bus.cpu_req = 1'b0; bus.cpu_we = ~we; bus.cpu_addr = ~a; bus.cpu_wdata = ~wd;
        seen_req = 1'b0; done = 1'b0; r = 0;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                chk("req_once", 32'(seen_req), 32'd0);
                chk("req_needed", 32'(need_mem), 32'd1);
                chk("req_while_ready", 32'(bus.mem_ready), 32'd1);
                chk("req_addr", 32'(bus.mem_addr), 32'(a));
                chk("req_we", 32'(bus.mem_we), 32'(we));
                if (we) begin
                    chk("wr_bus", 32'(mem_data), 32'({wd, wd}));
                    last_wr_bus = mem_data;
                end
                seen_req = 1'b1; r = k;
            end else begin
                exp_line = {ram[{bus.mem_addr[9:1], 1'b1}], ram[{bus.mem_addr[9:1], 1'b0}]};
                chk("bus_released", 32'(mem_data), 32'(exp_line));
            end
            if (bus.cpu_ready) begin
                done = 1'b1;
                chk("ready_cycle", 32'(k), need_mem ? 32'(r + 4) : 32'd2);
                if (!we) chk("rdata", 32'(bus.cpu_rdata), 32'(exp_rd));
                chk("hit_cnt", 32'(hit_cnt), 32'(sat(mh)));
                chk("miss_cnt", 32'(miss_cnt), 32'(sat(mm)));
                chk("busy_at_ready", 32'(bus.cpu_busy), 32'd0);
                last_rdy_k = k;
            end else begin
                chk("busy", 32'(bus.cpu_busy), 32'd1);
            end
        end
        if (!done) begin
            total_cnt++;
            $display("FAIL op_timeout: got no cpu_ready expected one for addr %0d", a);
        end
        last_req_k = r;
        if (we) mref[a] = wd;
        else if (!hit) begin
            mvalid[a[3:1]] = 1'b1;
            mtag[a[3:1]]   = int'(a[9:4]);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst_cpu_busy", 32'(bus.cpu_busy), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    endtask

    initial begin
        bit got;
        for (int i = 0; i < 1024; i++) mref[i] = init_val(10'(i));
        for (int i = 0; i < 8; i++) begin mvalid[i] = 1'b0; mtag[i] = 0; end
        mh = 0; mm = 0; last_req_k = 0; last_rdy_k = 0; last_wr_bus = '0;
        rst_n = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;

        op(1'b0, 10'd10, 10'd0);                 // cold read
        chk("cold_req_cycle", 32'(last_req_k), 32'd2);
        chk("cold_ready_cycle", 32'(last_rdy_k), 32'd6);
        chk("cold_rdata", 32'(bus.cpu_rdata), 32'd5);
        chk("cold_miss_cnt", 32'(miss_cnt), 32'd1);

        op(1'b0, 10'd11, 10'd0);                 // same line, odd word
        chk("hit_ready_cycle", 32'(last_rdy_k), 32'd2);
        chk("hit_rdata", 32'(bus.cpu_rdata), 32'd10);
        chk("hit_hit_cnt", 32'(hit_cnt), 32'd1);

        op(1'b1, 10'd12, 10'd3);                 // write miss, no allocate
        chk("wr_bus_literal", 32'(last_wr_bus), 32'h00C03);
        op(1'b0, 10'd12, 10'd0);
        chk("wr_then_read_rdata", 32'(bus.cpu_rdata), 32'd3);

        op(1'b0, 10'd26, 10'd0);                 // evicts addr 10 (index 5)
        op(1'b0, 10'd10, 10'd0);
        chk("conflict_rdata", 32'(bus.cpu_rdata), 32'd5);

        op(1'b1, 10'd10, 10'h2AA);               // write hit
        op(1'b0, 10'd10, 10'd0);
        chk("wr_hit_read_ready_cycle", 32'(last_rdy_k), 32'd2);
        chk("wr_hit_rdata", 32'(bus.cpu_rdata), 32'h2AA);

        // Reset while waiting on a slow RAM fill.
        ram_lat = 5;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'd40; bus.cpu_wdata = '0;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.mem_req) got = 1'b1;
        end
        if (!got) begin
            total_cnt++;
            $display("FAIL slow_req_timeout: got no mem_req expected one");
        end
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", 32'(bus.cpu_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
        mh = 0; mm = 0;
        @(negedge clk);
        rst_n = 1'b1;
        ram_lat = 1;
        op(1'b0, 10'd10, 10'd0);                 // first request waits for the RAM to go idle
        chk("post_reset_miss_cnt", 32'(miss_cnt), 32'd1);
        chk("post_reset_rdata", 32'(bus.cpu_rdata), 32'h2AA);
        op(1'b0, 10'd40, 10'd0);
        op(1'b0, 10'd50, 10'd0);
        op(1'b0, 10'd60, 10'd0);
        op(1'b0, 10'd70, 10'd0);
        chk("sat_miss_cnt", 32'(miss_cnt), 32'd3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1);
    end
endmodule
